// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared scan-code constants, decoder states and the set-2 to ASCII map.
package ps2_key_pkg;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  typedef enum logic [1:0] {S_WAIT, S_POP, S_GAP, S_DECODE} state_e;
  // Returns {valid, ascii}; valid is 0 for every code outside the typing set.
  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return {a != 8'h00, a};
  endfunction
endpackage

// File: rtl/key_fifo.sv
// key_fifo: small synchronous FIFO of ASCII key events; head is read combinationally from storage.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] dout_o
);
  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic wr_en, rd_en;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign rd_en = pop_i && !empty_o;
  // A pop in the same cycle frees the slot being written, so a push on full still lands.
  assign wr_en = push_i && (!full_o || rd_en);
  assign dout_o = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + {{AW{1'b0}}, wr_en};
      rd_q <= rd_q + {{AW{1'b0}}, rd_en};
    end
endmodule

// File: rtl/ps2_key_events.sv
// ps2_key_events: turns raw set-2 scan bytes into one queued ASCII event per key press.
module ps2_key_events import ps2_key_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_nextdata_n,
  output logic       ev_valid,
  output logic [7:0] ev_ascii,
  input  logic       ev_ready,
  output logic [7:0] held_ascii,
  output logic       overflow,
  output logic [7:0] key_count
);
  state_e state_q;
  logic [7:0] byte_q, held_code_q, held_code_d, held_ascii_q, held_ascii_d, key_count_q;
  logic brk_q, brk_d, ext_q, ext_d, nd_n_q, ovf_q, push, full, empty, ev_pop;
  logic [8:0] map;
  assign map = scan_to_ascii(byte_q);
  assign ev_valid = !empty;
  assign ev_pop = ev_valid && ev_ready;
  assign kb_nextdata_n = nd_n_q;
  assign held_ascii = held_ascii_q;
  assign overflow = ovf_q;
  assign key_count = key_count_q;
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    held_code_d = held_code_q;
    held_ascii_d = held_ascii_q;
    push = 1'b0;
    if (state_q == S_DECODE) begin
      if (byte_q == SC_BREAK) brk_d = 1'b1;
      else if (byte_q == SC_EXT) ext_d = 1'b1;
      else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (brk_q) begin
          held_code_d = (byte_q == held_code_q) ? 8'h00 : held_code_q;
          held_ascii_d = (byte_q == held_code_q) ? 8'h00 : held_ascii_q;
        end else if (byte_q != held_code_q || ext_q) begin
          // Typematic repeats of the held non-extended key fall through untouched.
          held_code_d = byte_q;
          push = !ext_q && map[8];
          held_ascii_d = push ? map[7:0] : 8'h00;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state_q <= S_WAIT;
      byte_q <= 8'h00;
      nd_n_q <= 1'b1;
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      held_code_q <= 8'h00;
      held_ascii_q <= 8'h00;
      key_count_q <= 8'h00;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: if (kb_ready) begin
          byte_q <= kb_data;
          nd_n_q <= 1'b0;
          state_q <= S_POP;
        end
        S_POP: begin
          nd_n_q <= 1'b1;
          state_q <= S_GAP;
        end
        S_GAP: state_q <= S_DECODE;
        default: state_q <= S_WAIT;
      endcase
      brk_q <= brk_d;
      ext_q <= ext_d;
      held_code_q <= held_code_d;
      held_ascii_q <= held_ascii_d;
      if (push && (!full || ev_pop)) key_count_q <= key_count_q + 8'd1;
      if (push && full && !ev_pop) ovf_q <= 1'b1;
    end
  key_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk),
    .clrn(clrn),
    .push_i(push),
    .din_i(held_ascii_d),
    .pop_i(ev_pop),
    .full_o(full),
    .empty_o(empty),
    .dout_o(ev_ascii)
  );
endmodule

// File: tb/tb_ps2_key_events.sv
// tb_ps2_key_events: scoreboard bench with a behavioural PS/2 receiver feeding the decoder.
module tb_ps2_key_events;
  logic clk = 1'b0, clrn = 1'b0, kb_ready = 1'b0, ev_ready = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic kb_nextdata_n, ev_valid, overflow;
  logic [7:0] ev_ascii, held_ascii, key_count;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int pass_cnt = 0, total_cnt = 0;

  ps2_key_events dut (
    .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_nextdata_n(kb_nextdata_n), .ev_valid(ev_valid), .ev_ascii(ev_ascii),
    .ev_ready(ev_ready), .held_ascii(held_ascii), .overflow(overflow), .key_count(key_count)
  );

  always #5 clk = ~clk;

  // Receiver model: drops its head byte when the decoder strobes kb_nextdata_n low.
  always @(negedge clk) begin
    if (!kb_nextdata_n && rx_q.size() != 0) void'(rx_q.pop_front());
    kb_ready = rx_q.size() != 0;
    kb_data = kb_ready ? rx_q[0] : 8'h00;
  end

  // Scoreboard: every accepted head must match the oldest expected event.
  always @(negedge clk) begin
    if (clrn && ev_valid && ev_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) $display("FAIL unexpected_event got=%h want=none", ev_ascii);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ev_ascii !== e) $display("FAIL event got=%h want=%h", ev_ascii, e);
        else pass_cnt++;
      end
    end
  end

  task automatic put(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && rx_q.size() != 0; i++) @(negedge clk);
    if (rx_q.size() != 0) begin
      total_cnt++;
      $display("FAIL idle_timeout got=%0d want=0 bytes left", rx_q.size());
      rx_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 ev_ready = r;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clrn = 1'b0;
    rx_q.delete();
    exp_q.delete();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (kb_nextdata_n !== 1'b1) $display("FAIL rst_nextdata got=%b want=1", kb_nextdata_n); else pass_cnt++;
    total_cnt++; if (ev_valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", ev_valid); else pass_cnt++;
    total_cnt++; if (ev_ascii !== 8'h00) $display("FAIL rst_ascii got=%h want=00", ev_ascii); else pass_cnt++;
    total_cnt++; if (held_ascii !== 8'h00) $display("FAIL rst_held got=%h want=00", held_ascii); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow got=%b want=0", overflow); else pass_cnt++;
    total_cnt++; if (key_count !== 8'h00) $display("FAIL rst_count got=%h want=00", key_count); else pass_cnt++;
  endtask

  task automatic test_press_release();
    apply_reset();
    set_ready(1'b1);
    exp_q.push_back(8'h61);
    put(8'h1C);
    wait_idle();
    total_cnt++; if (held_ascii !== 8'h61) $display("FAIL pr_held_make got=%h want=61", held_ascii); else pass_cnt++;
    put(8'hF0); put(8'h1C);
    wait_idle();
    total_cnt++; if (held_ascii !== 8'h00) $display("FAIL pr_held_break got=%h want=00", held_ascii); else pass_cnt++;
    total_cnt++; if (key_count !== 8'd1) $display("FAIL pr_count got=%0d want=1", key_count); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL pr_pending got=%0d want=0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_typematic();
    apply_reset();
    set_ready(1'b1);
    exp_q.push_back(8'h61);
    repeat (4) put(8'h1C);
    put(8'hF0); put(8'h1C);
    wait_idle();
    total_cnt++; if (key_count !== 8'd1) $display("FAIL tm_count got=%0d want=1", key_count); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL tm_pending got=%0d want=0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_extended();
    apply_reset();
    set_ready(1'b1);
    put(8'hE0); put(8'h75); put(8'hE0); put(8'hF0); put(8'h75);
    wait_idle();
    total_cnt++; if (key_count !== 8'd0) $display("FAIL ext_arrow_count got=%0d want=0", key_count); else pass_cnt++;
    exp_q.push_back(8'h62);
    put(8'h32);
    wait_idle();
    total_cnt++; if (held_ascii !== 8'h62) $display("FAIL ext_held got=%h want=62", held_ascii); else pass_cnt++;
    total_cnt++; if (key_count !== 8'd1) $display("FAIL ext_count got=%0d want=1", key_count); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL ext_pending got=%0d want=0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    apply_reset();
    set_ready(1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k < 8) exp_q.push_back(8'h31 + 8'(k));
      put(codes[k]); put(8'hF0); put(codes[k]);
    end
    wait_idle();
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b want=1", overflow); else pass_cnt++;
    total_cnt++; if (key_count !== 8'd8) $display("FAIL ovf_count got=%0d want=8", key_count); else pass_cnt++;
    total_cnt++; if (ev_ascii !== 8'h31) $display("FAIL ovf_head got=%h want=31", ev_ascii); else pass_cnt++;
    set_ready(1'b1);
    for (int i = 0; i < 40 && ev_valid; i++) @(negedge clk);
    total_cnt++; if (exp_q.size() != 0) $display("FAIL ovf_drain got=%0d want=0 left", exp_q.size()); else pass_cnt++;
    total_cnt++; if (ev_valid !== 1'b0) $display("FAIL ovf_empty got=%b want=0", ev_valid); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", overflow); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_ready(1'b0);
    put(8'h1C); put(8'hF0); put(8'h1C); put(8'hF0);
    wait_idle();
    total_cnt++; if (ev_valid !== 1'b1) $display("FAIL mid_queued got=%b want=1", ev_valid); else pass_cnt++;
    @(negedge clk);
    clrn = 1'b0;
    #1;
    total_cnt++; if (ev_valid !== 1'b0) $display("FAIL mid_valid got=%b want=0", ev_valid); else pass_cnt++;
    total_cnt++; if (ev_ascii !== 8'h00) $display("FAIL mid_ascii got=%h want=00", ev_ascii); else pass_cnt++;
    total_cnt++; if (key_count !== 8'h00) $display("FAIL mid_count got=%h want=00", key_count); else pass_cnt++;
    total_cnt++; if (kb_nextdata_n !== 1'b1) $display("FAIL mid_nextdata got=%b want=1", kb_nextdata_n); else pass_cnt++;
    @(negedge clk);
    clrn = 1'b1;
    set_ready(1'b1);
    exp_q.push_back(8'h61);
    put(8'h1C);
    wait_idle();
    total_cnt++; if (held_ascii !== 8'h61) $display("FAIL mid_held got=%h want=61", held_ascii); else pass_cnt++;
    total_cnt++; if (key_count !== 8'd1) $display("FAIL mid_after_count got=%0d want=1", key_count); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL mid_pending got=%0d want=0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lows = 0, last = 0;
    apply_reset();
    set_ready(1'b1);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    put(8'h1C); put(8'hF0); put(8'h1C); put(8'h32); put(8'hF0);
    put(8'h32); put(8'h21); put(8'hF0); put(8'h21);
    for (int cyc = 0; cyc < 100 && lows < 9; cyc++) begin
      @(negedge clk);
      if (!kb_nextdata_n) begin
        if (lows > 0) begin
          total_cnt++;
          if (cyc - last != 4) $display("FAIL b2b_gap got=%0d want=4", cyc - last); else pass_cnt++;
        end
        lows++;
        last = cyc;
      end
    end
    wait_idle();
    total_cnt++; if (lows != 9) $display("FAIL b2b_pops got=%0d want=9", lows); else pass_cnt++;
    total_cnt++; if (key_count !== 8'd3) $display("FAIL b2b_count got=%0d want=3", key_count); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_pending got=%0d want=0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_typematic();
    test_extended();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
